// File: rtl/fp_accum.sv
// Frame accumulator: sums N_TERMS signed fixed-point products with guard bits, then reports range flags.
// Optional output saturation is enabled with macro FP_ACCUM_SAT_EN (default build wraps).
module fp_accum #(
  parameter int W_len   = 16,
  parameter int W_fract = 14,
  parameter int N_TERMS = 8,
  parameter int W_guard = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W_len-1:0] in_data,
  input  logic             in_ovf,
  input  logic             in_unf,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_len-1:0] sum,
  output logic             sum_ovf,
  output logic             sum_unf,
  output logic             sticky_err,
  output logic             busy
);

  localparam int W_ACC = W_len + W_guard;
  localparam int CNT_W = (N_TERMS < 2) ? 1 : $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_TERMS - 1);

  // Output range limits, sign-extended to accumulator width.
  localparam logic signed [W_ACC-1:0] SUM_MAX = {{(W_guard + 1){1'b0}}, {(W_len - 1){1'b1}}};
  localparam logic signed [W_ACC-1:0] SUM_MIN = {{(W_guard + 1){1'b1}}, {(W_len - 1){1'b0}}};

  generate
    if (W_fract < 0 || W_fract >= W_len) begin : g_bad_fract
      $error("fp_accum: W_fract must lie in 0..W_len-1");
    end
    if (N_TERMS < 1 || N_TERMS > (1 << W_guard)) begin : g_bad_terms
      $error("fp_accum: N_TERMS must lie in 1..2**W_guard");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic signed [W_ACC-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic                      sticky_q, sticky_d;
  logic        [W_len-1:0]   sum_q, sum_d;
  logic                      ovf_q, ovf_d;
  logic                      unf_q, unf_d;

  logic signed [W_ACC-1:0]   beat_ext;
  logic signed [W_ACC-1:0]   acc_sum;
  logic                      fin_ovf;
  logic                      fin_unf;
  logic        [W_len-1:0]   fin_sum;
  logic                      beat_fire;

  // Datapath: next accumulator value and its range classification.
  always_comb begin
    beat_ext = {{W_guard{in_data[W_len-1]}}, in_data};
    acc_sum  = acc_q + beat_ext;
    fin_ovf  = (acc_sum > SUM_MAX);
    fin_unf  = (acc_sum < SUM_MIN);
`ifdef FP_ACCUM_SAT_EN
    if (fin_ovf) begin
      fin_sum = {1'b0, {(W_len - 1){1'b1}}};
    end else if (fin_unf) begin
      fin_sum = {1'b1, {(W_len - 1){1'b0}}};
    end else begin
      fin_sum = acc_sum[W_len-1:0];
    end
`else
    fin_sum = acc_sum[W_len-1:0];
`endif
  end

  assign beat_fire = (state_q == S_ACCUM) && in_valid;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat_fire) begin
          acc_d    = acc_sum;
          cnt_d    = cnt_q + 1'b1;
          sticky_d = sticky_q | in_ovf | in_unf;
          // Result registers are loaded only with the final sum so they stay frozen in DONE.
          if (cnt_q == LAST_BEAT) begin
            sum_d   = fin_sum;
            ovf_d   = fin_ovf;
            unf_d   = fin_unf;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign in_ready   = (state_q == S_ACCUM);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign sum        = sum_q;
  assign sum_ovf    = ovf_q;
  assign sum_unf    = unf_q;
  assign sticky_err = sticky_q;

endmodule

// File: tb/tb_fp_accum.sv
// Self-checking bench for fp_accum (N_TERMS=4): directed frames plus random frames against an integer model.
module tb_fp_accum;

  localparam int W  = 16;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ovf = 1'b0;
  logic          in_unf = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          sum_ovf;
  logic          sum_unf;
  logic          sticky_err;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp_accum #(
    .W_len  (16),
    .W_fract(14),
    .N_TERMS(NT),
    .W_guard(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ovf    (in_ovf),
    .in_unf    (in_unf),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .sum_ovf   (sum_ovf),
    .sum_unf   (sum_unf),
    .sticky_err(sticky_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_ready"},  32'(in_ready), 32'd0);
    check({tag, "_valid"},  32'(out_valid), 32'd0);
    check({tag, "_sum"},    32'(sum), 32'd0);
    check({tag, "_ovf"},    32'(sum_ovf), 32'd0);
    check({tag, "_unf"},    32'(sum_unf), 32'd0);
    check({tag, "_sticky"}, 32'(sticky_err), 32'd0);
  endtask

  // One complete frame: start, NT accepted beats, hold in DONE, then drain.
  task automatic run_frame(input string name, input logic [W-1:0] d[NT], input bit ov[NT],
                           input bit un[NT], input int hold, input bit noisy);
    longint      total;
    bit          stk;
    bit          e_ovf, e_unf;
    logic [W-1:0] e_sum;
    check({name, "_idle_busy"},  32'(busy), 32'd0);
    check({name, "_idle_ready"}, 32'(in_ready), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check({name, "_accum_busy"},   32'(busy), 32'd1);
    check({name, "_accum_ready"},  32'(in_ready), 32'd1);
    check({name, "_start_sticky"}, 32'(sticky_err), 32'd0);
    total = 0;
    stk = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (noisy && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_ovf   = 1'b1;
        start    = 1'b1;
        step();
        check({name, "_gap_ready"}, 32'(in_ready), 32'd1);
      end
      start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid = 1'b1;
      in_data  = d[i];
      in_ovf   = ov[i];
      in_unf   = un[i];
      total   += longint'($signed(d[i]));
      stk      = stk | ov[i] | un[i];
      check({name, "_pre_done_valid"}, 32'(out_valid), 32'd0);
      step();
    end
    in_valid = 1'b0;
    in_ovf   = 1'b0;
    in_unf   = 1'b0;
    start    = 1'b0;

    e_ovf = (total > 64'sd32767);
    e_unf = (total < -64'sd32768);
`ifdef FP_ACCUM_SAT_EN
    if (e_ovf)      e_sum = 16'h7FFF;
    else if (e_unf) e_sum = 16'h8000;
    else            e_sum = total[W-1:0];
`else
    e_sum = total[W-1:0];
`endif

    for (int h = 0; h <= hold; h++) begin
      check({name, "_done_valid"},  32'(out_valid), 32'd1);
      check({name, "_done_ready"},  32'(in_ready), 32'd0);
      check({name, "_done_sum"},    32'(sum), 32'(e_sum));
      check({name, "_done_ovf"},    32'(sum_ovf), 32'(e_ovf));
      check({name, "_done_unf"},    32'(sum_unf), 32'(e_unf));
      check({name, "_done_sticky"}, 32'(sticky_err), 32'(stk));
      in_valid  = 1'b1;
      in_data   = W'($urandom);
      in_ovf    = 1'b1;
      start     = (h < hold);
      out_ready = (h == hold);
      step();
    end
    in_valid  = 1'b0;
    in_ovf    = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    check({name, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({name, "_drain_busy"},  32'(busy), 32'd0);
    $display("frame %s: total=%0d sum=%h ovf=%0b unf=%0b sticky=%0b hold=%0d",
             name, total, sum, e_ovf, e_unf, stk, hold);
  endtask

  initial begin
    logic [W-1:0] d[NT];
    bit           ov[NT];
    bit           un[NT];
    bit           zf[NT];
    for (int i = 0; i < NT; i++) zf[i] = 1'b0;

    reset = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b1;
    step();

    d = '{16'h1000, 16'h1000, 16'hF000, 16'h0800};
    run_frame("basic", d, zf, zf, 0, 1'b0);

    d = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
    run_frame("ovf", d, zf, zf, 3, 1'b0);

    d = '{16'hC000, 16'hC000, 16'hC000, 16'hC000};
    run_frame("unf", d, zf, zf, 3, 1'b0);

    ov = '{1'b0, 1'b0, 1'b1, 1'b0};
    d  = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    run_frame("sticky", d, ov, zf, 1, 1'b0);
    d  = '{16'h0001, 16'hFFFF, 16'h0002, 16'hFFFE};
    run_frame("sticky_clr", d, zf, zf, 0, 1'b0);

    // Reset after two beats (one flagged) must discard the frame entirely.
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h3000; in_ovf = 1'b1;
    step();
    in_ovf = 1'b0; in_data = 16'h3000;
    step();
    check("midreset_sticky_pre", 32'(sticky_err), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    in_valid = 1'b0;
    check_all_zero("midreset");
    step();
    check("midreset_no_valid", 32'(out_valid), 32'd0);
    d = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    run_frame("post_reset", d, zf, zf, 0, 1'b0);

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < NT; i++) begin
        d[i]  = (f % 3 == 0) ? W'($urandom) : W'($urandom_range(0, 16'h3FFF) - (f % 3 == 1 ? 0 : 16'h2000));
        ov[i] = ($urandom_range(0, 7) == 0);
        un[i] = ($urandom_range(0, 7) == 0);
      end
      run_frame($sformatf("rand%0d", f), d, ov, un, $urandom_range(0, 3), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_accum.md
FP_ACCUM -- requirements
Module: fp_accum

Interface
REQ-001 The block SHALL have parameter W_len, default 16, total width of input and output samples in signed fixed point.
REQ-002 The block SHALL have parameter W_fract, default 14, fractional bits of input and output (Q2.14 at defaults).
REQ-003 The block SHALL have parameter N_TERMS, default 8, products summed per frame (legal range 1..2^W_guard).
REQ-004 The block SHALL have parameter W_guard, default 4, guard bits: internal accumulator width is W_len+W_guard.
REQ-005 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, frame-start pulse, honoured only in IDLE.
REQ-008 The block SHALL have port in_valid, input, 1, upstream multiplier product valid.
REQ-009 The block SHALL have port in_data, input, W_len, signed product from the multiplier stage.
REQ-010 The block SHALL have port in_ovf, input, 1, upstream multiplier overflow flag for in_data.
REQ-011 The block SHALL have port in_unf, input, 1, upstream multiplier underflow flag for in_data.
REQ-012 The block SHALL have port in_ready, output, 1, block accepts a product this cycle.
REQ-013 The block SHALL have port out_valid, output, 1, frame sum available.
REQ-014 The block SHALL have port out_ready, input, 1, downstream consumes the frame sum.
REQ-015 The block SHALL have port sum, output, W_len, signed frame sum in Q(W_len-W_fract).W_fract.
REQ-016 The block SHALL have port sum_ovf, output, 1, frame sum above the maximum representable value.
REQ-017 The block SHALL have port sum_unf, output, 1, frame sum below the minimum representable value.
REQ-018 The block SHALL have port sticky_err, output, 1, some accepted beat in the frame carried in_ovf or in_unf.
REQ-019 The block SHALL have port busy, output, 1, state is not IDLE.

Function
REQ-020 The block SHALL implement states IDLE, ACCUM and DONE.
REQ-021 In IDLE, start=1 SHALL clear the accumulator, beat counter and sticky_err and move to ACCUM on the next edge.
REQ-022 In ACCUM, in_ready SHALL be 1; in IDLE and DONE it SHALL be 0.
REQ-023 A beat is accepted when in_valid and in_ready are both 1; the accumulator SHALL add sign-extended in_data and the counter SHALL increment.
REQ-024 An accepted beat with in_ovf or in_unf set SHALL set sticky_err, which then holds until the next accepted start.
REQ-025 Acceptance of beat number N_TERMS SHALL move the state to DONE, and out_valid SHALL be 1 in the following cycle (1-cycle latency).
REQ-026 In DONE, sum, sum_ovf, sum_unf and sticky_err SHALL hold stable until out_ready=1; that edge SHALL move the state to IDLE.
REQ-027 start outside IDLE SHALL be ignored; in_valid outside ACCUM SHALL be ignored.
REQ-028 sum_ovf SHALL be set when acc > 2^(W_len-1)-1, sum_unf when acc < -2^(W_len-1), evaluated on the final accumulator value.
REQ-029 With N_TERMS <= 2^W_guard the internal accumulator SHALL never wrap.

Reset
REQ-030 When reset=0 at a clock edge, the state SHALL go to IDLE, and the accumulator, counter, sum, all flags, out_valid and busy SHALL clear to 0 in any state.
REQ-031 A reset mid-frame SHALL discard the partial sum; no out_valid SHALL be produced for that frame.

Configuration
REQ-032 With macro FP_ACCUM_SAT_EN defined, sum SHALL saturate to 2^(W_len-1)-1 on sum_ovf and to -2^(W_len-1) on sum_unf.
REQ-033 With FP_ACCUM_SAT_EN undefined, sum SHALL be acc[W_len-1:0] (wrap); sum_ovf and sum_unf SHALL still be reported.

Verification
REQ-034 N_TERMS=4, beats 0x1000,0x1000,0xF000,0x0800 -> sum=0x1800, sum_ovf=0, sum_unf=0, out_valid one cycle after the 4th beat.
REQ-035 N_TERMS=4, four beats of 0x2000 -> sum_ovf=1, sum=0x7FFF with FP_ACCUM_SAT_EN, 0x8000 without.
REQ-036 N_TERMS=4, four beats of 0xC000 -> sum_unf=1, sum=0x8000 with FP_ACCUM_SAT_EN, 0x0000 without.
REQ-037 out_ready held 0 for 3 cycles in DONE -> out_valid and sum stable, in_ready=0, extra in_valid beats ignored.
REQ-038 One beat with in_ovf=1 -> sticky_err=1 in DONE; next start -> sticky_err=0.
REQ-039 reset=0 for one cycle after 2 of 4 beats -> IDLE, all outputs 0; a fresh frame then sums correctly.
